// File: rtl/duc_pkg.sv
// Shared types and constants for the DUC sample FIFO.
package duc_pkg;

    typedef enum logic {
        DUC_FIFO_IDLE,
        DUC_FIFO_RUN
    } duc_fifo_state_t;

    localparam int DUC_UFLOW_CNT_W = 16;

endpackage

// File: rtl/duc_fifo_ram.sv
// Purpose: simple dual-port sample store, DEPTH x DW, holding {I,Q}.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none; the caller guarantees no write to an occupied slot.
module duc_fifo_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clock,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/duc_sample_fifo.sv
// Purpose: elastic I/Q buffer ahead of the upconverter; primes to START_LEVEL, zero-pads on underflow (DUC_FIFO_UFLOW_CNT_EN adds an underflow counter).
// Latency: first sample reaches the head register one cycle after the level reaches START_LEVEL.
// Backpressure: o_ready drops when the memory is full; the read side never stalls.
module duc_sample_fifo
    import duc_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 64,
    parameter int START_LEVEL = 32
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_inph_data,
    input  logic [WIDTH-1:0]           i_quad_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [WIDTH-1:0]           o_inph_data,
    output logic [WIDTH-1:0]           o_quad_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_running,
    output logic                       o_underflow,
    input  logic                       i_clear_underflow
`ifdef DUC_FIFO_UFLOW_CNT_EN
    ,
    output logic [DUC_UFLOW_CNT_W-1:0] o_underflow_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    duc_fifo_state_t  state, state_nxt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] head_i, head_q;
    logic [2*WIDTH-1:0] rd_dat;
    logic             push, pop, uflow_evt, uflow_set, load_zero;

    assign o_ready   = i_reset_n && (level != LW'(DEPTH));
    assign push      = i_valid && o_ready;
    assign uflow_set = uflow_evt && !i_flush;

    duc_fifo_ram #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clock (i_clock),
        .wr_vld  (push && !i_flush),
        .wr_addr (wr_ptr),
        .wr_dat  ({i_inph_data, i_quad_data}),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_flush) begin
            state <= DUC_FIFO_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pops use the registered level only: a same-cycle push cannot rescue an empty read.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        uflow_evt = 1'b0;
        load_zero = 1'b0;
        case (state)
            DUC_FIFO_IDLE: begin
                if (level >= LW'(START_LEVEL)) begin
                    pop       = 1'b1;
                    state_nxt = DUC_FIFO_RUN;
                end
            end
            DUC_FIFO_RUN: begin
                if (i_ready) begin
                    if (level != '0) begin
                        pop = 1'b1;
                    end else begin
                        uflow_evt = 1'b1;
                        load_zero = 1'b1;
                        state_nxt = DUC_FIFO_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head_i <= '0;
            head_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr           <= rd_ptr + AW'(1);
                {head_i, head_q} <= rd_dat;
            end else if (load_zero) begin
                head_i <= '0;
                head_q <= '0;
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            o_underflow <= 1'b0;
        end else if (uflow_set) begin
            o_underflow <= 1'b1;
        end else if (i_clear_underflow) begin
            o_underflow <= 1'b0;
        end
    end

`ifdef DUC_FIFO_UFLOW_CNT_EN
    logic [DUC_UFLOW_CNT_W-1:0] uflow_cnt;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            uflow_cnt <= '0;
        end else if (i_clear_underflow) begin
            uflow_cnt <= DUC_UFLOW_CNT_W'(uflow_set);
        end else if (uflow_set && (uflow_cnt != '1)) begin
            uflow_cnt <= uflow_cnt + DUC_UFLOW_CNT_W'(1);
        end
    end

    assign o_underflow_count = uflow_cnt;
`endif

    assign o_inph_data = head_i;
    assign o_quad_data = head_q;
    assign o_level     = level;
    assign o_running   = (state == DUC_FIFO_RUN);

endmodule

// File: tb/tb_duc_sample_fifo.sv
// Self-checking bench for duc_sample_fifo: scoreboard queue of accepted samples, popped as the head advances.
module tb_duc_sample_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int START = 32;
    localparam int LW    = 7;

    logic             i_clock = 1'b0;
    logic             i_reset_n = 1'b0;
    logic             i_flush = 1'b0;
    logic [WIDTH-1:0] i_inph_data = '0;
    logic [WIDTH-1:0] i_quad_data = '0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] o_inph_data;
    logic [WIDTH-1:0] o_quad_data;
    logic             i_ready = 1'b0;
    logic [LW-1:0]    o_level;
    logic             o_running;
    logic             o_underflow;
    logic             i_clear_underflow = 1'b0;
`ifdef DUC_FIFO_UFLOW_CNT_EN
    logic [15:0]      o_underflow_count;
`endif

    always #5 i_clock = ~i_clock;

    duc_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .START_LEVEL(START)) dut (
        .i_clock           (i_clock),
        .i_reset_n         (i_reset_n),
        .i_flush           (i_flush),
        .i_inph_data       (i_inph_data),
        .i_quad_data       (i_quad_data),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .o_inph_data       (o_inph_data),
        .o_quad_data       (o_quad_data),
        .i_ready           (i_ready),
        .o_level           (o_level),
        .o_running         (o_running),
        .o_underflow       (o_underflow),
        .i_clear_underflow (i_clear_underflow)
`ifdef DUC_FIFO_UFLOW_CNT_EN
        ,
        .o_underflow_count (o_underflow_count)
`endif
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb[$];
    logic [15:0] exp_i = '0;
    logic [15:0] exp_q = '0;
    logic        exp_run = 1'b0;
    logic        exp_uf = 1'b0;
    int          exp_cnt = 0;

    // Drive one cycle of stimulus, advance the reference model, sample #1 after the edge.
    task automatic step(input logic v, input logic [15:0] di, input logic [15:0] dq,
                        input logic rdy, input logic fl, input logic clr, input logic rst);
        logic acc;
        logic ev;
        i_valid = v; i_inph_data = di; i_quad_data = dq; i_ready = rdy;
        i_flush = fl; i_clear_underflow = clr; i_reset_n = rst;
        acc = rst && v && (sb.size() != DEPTH);
        ev  = 1'b0;
        if (!rst) begin
            sb.delete(); exp_i = '0; exp_q = '0; exp_run = 1'b0; exp_uf = 1'b0; exp_cnt = 0;
        end else if (fl) begin
            sb.delete(); exp_i = '0; exp_q = '0; exp_run = 1'b0;
            if (clr) begin exp_uf = 1'b0; exp_cnt = 0; end
        end else begin
            if (!exp_run) begin
                if (sb.size() >= START) begin {exp_i, exp_q} = sb.pop_front(); exp_run = 1'b1; end
            end else if (rdy) begin
                if (sb.size() > 0) {exp_i, exp_q} = sb.pop_front();
                else begin exp_i = '0; exp_q = '0; ev = 1'b1; exp_run = 1'b0; end
            end
            if (acc) sb.push_back({di, dq});
            if (clr) exp_cnt = ev ? 1 : 0;
            else if (ev && exp_cnt < 65535) exp_cnt++;
            if (ev) exp_uf = 1'b1;
            else if (clr) exp_uf = 1'b0;
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (o_ready !== 1'b0 || o_level !== '0 || o_running !== 1'b0 || o_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b level=%0d run=%b uf=%b, required 0/0/0/0", o_ready, o_level, o_running, o_underflow);
        end
        vectors++;
        if (o_inph_data !== 16'h0 || o_quad_data !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_head: i=%h q=%h, required 0/0", o_inph_data, o_quad_data);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        vectors++;
        if (o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, required 1", o_ready);
        end
    endtask

    task automatic test_prime(input int base);
        for (int n = 0; n < START; n++) begin
            step(1, 16'(base + n), 16'(-(base + n)), 0, 0, 0, 1);
            vectors++;
            if (o_level !== LW'(n + 1) || o_running !== 1'b0 || o_inph_data !== 16'h0 || o_quad_data !== 16'h0) begin
                miscompares++;
                $display("FAIL prime_fill n=%0d: level=%0d run=%b i=%h q=%h, required %0d/0/0/0", n, o_level, o_running, o_inph_data, o_quad_data, n + 1);
            end
        end
        step(0, 0, 0, 0, 0, 0, 1);
        vectors++;
        if (o_level !== LW'(31) || o_running !== 1'b1 || o_inph_data !== 16'(base) || o_quad_data !== 16'(-base)) begin
            miscompares++;
            $display("FAIL prime_start: level=%0d run=%b i=%h q=%h, required 31/1/%h/%h", o_level, o_running, o_inph_data, o_quad_data, 16'(base), 16'(-base));
        end
    endtask

    task automatic test_drain();
        for (int k = 1; k < START; k++) begin
            repeat (3) step(0, 0, 0, 0, 0, 0, 1);
            vectors++;
            if (o_inph_data !== 16'(k - 1)) begin
                miscompares++;
                $display("FAIL drain_hold k=%0d: i=%h, required %h", k, o_inph_data, 16'(k - 1));
            end
            step(0, 0, 0, 1, 0, 0, 1);
            vectors++;
            if (o_inph_data !== 16'(k) || o_quad_data !== 16'(-k) || o_inph_data !== exp_i || o_quad_data !== exp_q) begin
                miscompares++;
                $display("FAIL drain_step k=%0d: i=%h q=%h, required %h/%h", k, o_inph_data, o_quad_data, 16'(k), 16'(-k));
            end
        end
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        vectors++;
        if (o_inph_data !== 16'h0 || o_quad_data !== 16'h0 || o_underflow !== 1'b1 || o_running !== 1'b0 || o_level !== '0) begin
            miscompares++;
            $display("FAIL drain_underflow: i=%h q=%h uf=%b run=%b level=%0d, required 0/0/1/0/0", o_inph_data, o_quad_data, o_underflow, o_running, o_level);
        end
        step(0, 0, 0, 1, 0, 0, 1);
        vectors++;
        if (o_inph_data !== 16'h0 || o_running !== 1'b0 || o_level !== '0) begin
            miscompares++;
            $display("FAIL idle_consume: i=%h run=%b level=%0d, required 0/0/0", o_inph_data, o_running, o_level);
        end
    endtask

    task automatic test_full();
        step(0, 0, 0, 0, 1, 0, 1);
        vectors++;
        if (o_level !== '0 || o_running !== 1'b0 || o_underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL full_preflush: level=%0d run=%b uf=%b, required 0/0/1", o_level, o_running, o_underflow);
        end
        for (int k = 0; k < DEPTH; k++) begin
            step(1, 16'(100 + k), 16'(200 + k), 0, 0, 0, 1);
            vectors++;
            if (o_ready !== 1'b1 || o_level !== LW'(sb.size())) begin
                miscompares++;
                $display("FAIL full_fill k=%0d: ready=%b level=%0d, required 1/%0d", k, o_ready, o_level, sb.size());
            end
        end
        vectors++;
        if (o_level !== LW'(63) || o_running !== 1'b1 || o_inph_data !== 16'd100 || o_quad_data !== 16'd200) begin
            miscompares++;
            $display("FAIL full_63: level=%0d run=%b i=%h q=%h, required 63/1/0064/00c8", o_level, o_running, o_inph_data, o_quad_data);
        end
        step(1, 16'd500, 16'd600, 0, 0, 0, 1);
        vectors++;
        if (o_level !== LW'(64) || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_64: level=%0d ready=%b, required 64/0", o_level, o_ready);
        end
        step(1, 16'd501, 16'd601, 0, 0, 0, 1);
        vectors++;
        if (o_level !== LW'(64) || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_refuse: level=%0d ready=%b, required 64/0", o_level, o_ready);
        end
        step(0, 0, 0, 1, 0, 0, 1);
        vectors++;
        if (o_level !== LW'(63) || o_ready !== 1'b1 || o_inph_data !== 16'd101 || o_quad_data !== 16'd201) begin
            miscompares++;
            $display("FAIL full_pop: level=%0d ready=%b i=%h, required 63/1/0065", o_level, o_ready, o_inph_data);
        end
    endtask

    task automatic test_flush();
        while (sb.size() > 40) begin
            step(0, 0, 0, 1, 0, 0, 1);
            vectors++;
            if (o_inph_data !== exp_i || o_quad_data !== exp_q) begin
                miscompares++;
                $display("FAIL flush_pop: i=%h q=%h, required %h/%h", o_inph_data, o_quad_data, exp_i, exp_q);
            end
        end
        vectors++;
        if (o_level !== LW'(40)) begin
            miscompares++;
            $display("FAIL flush_level40: got %0d, required 40", o_level);
        end
        step(1, 16'd777, 16'd888, 0, 1, 0, 1);
        vectors++;
        if (o_level !== '0 || o_inph_data !== 16'h0 || o_quad_data !== 16'h0 || o_running !== 1'b0 || o_underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_clear: level=%0d i=%h q=%h run=%b uf=%b, required 0/0/0/0/1", o_level, o_inph_data, o_quad_data, o_running, o_underflow);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        vectors++;
        if (o_level !== '0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_drop: level=%0d ready=%b, required 0/1", o_level, o_ready);
        end
    endtask

    task automatic test_uflow_clear();
        step(0, 0, 0, 0, 1, 0, 1);
        test_prime(1000);
        while (sb.size() > 0) begin
            step(0, 0, 0, 1, 0, 0, 1);
            vectors++;
            if (o_inph_data !== exp_i || o_quad_data !== exp_q) begin
                miscompares++;
                $display("FAIL uclr_pop: i=%h q=%h, required %h/%h", o_inph_data, o_quad_data, exp_i, exp_q);
            end
        end
        step(1, 16'h55, 16'haa, 1, 0, 1, 1);
        vectors++;
        if (o_underflow !== 1'b1 || o_running !== 1'b0 || o_inph_data !== 16'h0 || o_level !== LW'(1)) begin
            miscompares++;
            $display("FAIL uclr_same_cycle: uf=%b run=%b i=%h level=%0d, required 1/0/0/1", o_underflow, o_running, o_inph_data, o_level);
        end
`ifdef DUC_FIFO_UFLOW_CNT_EN
        vectors++;
        if (o_underflow_count !== 16'(exp_cnt) || o_underflow_count !== 16'd1) begin
            miscompares++;
            $display("FAIL uclr_count1: got %0d, required 1", o_underflow_count);
        end
`endif
        step(0, 0, 0, 0, 0, 1, 1);
        vectors++;
        if (o_underflow !== 1'b0 || o_level !== LW'(1)) begin
            miscompares++;
            $display("FAIL uclr_clear: uf=%b level=%0d, required 0/1", o_underflow, o_level);
        end
`ifdef DUC_FIFO_UFLOW_CNT_EN
        vectors++;
        if (o_underflow_count !== 16'd0) begin
            miscompares++;
            $display("FAIL uclr_count0: got %0d, required 0", o_underflow_count);
        end
`endif
    endtask

    task automatic test_back_to_back_reset();
        step(0, 0, 0, 0, 1, 0, 1);
        test_prime(2000);
        repeat (11) step(0, 0, 0, 1, 0, 0, 1);
        vectors++;
        if (o_level !== LW'(20) || o_inph_data !== exp_i || o_inph_data !== 16'd2011) begin
            miscompares++;
            $display("FAIL b2b_level20: level=%0d i=%h, required 20/07db", o_level, o_inph_data);
        end
        step(1, 16'd3000, 16'd3001, 1, 0, 0, 1);
        vectors++;
        if (o_level !== LW'(20) || o_inph_data !== exp_i || o_quad_data !== exp_q) begin
            miscompares++;
            $display("FAIL b2b_pushpop: level=%0d i=%h q=%h, required 20/%h/%h", o_level, o_inph_data, o_quad_data, exp_i, exp_q);
        end
        step(1, 16'd3002, 16'd3003, 1, 0, 0, 0);
        vectors++;
        if (o_level !== '0 || o_inph_data !== 16'h0 || o_quad_data !== 16'h0 || o_running !== 1'b0 || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: level=%0d i=%h q=%h run=%b ready=%b, required 0/0/0/0/0", o_level, o_inph_data, o_quad_data, o_running, o_ready);
        end
        step(1, 16'd3004, 16'd3005, 0, 0, 0, 0);
        vectors++;
        if (o_ready !== 1'b0 || o_level !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset_hold: ready=%b level=%0d, required 0/0", o_ready, o_level);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        vectors++;
        if (o_ready !== 1'b1 || o_level !== '0 || o_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_release: ready=%b level=%0d uf=%b, required 1/0/0", o_ready, o_level, o_underflow);
        end
    endtask

    initial begin
        test_reset();
        test_prime(0);
        test_drain();
        test_full();
        test_flush();
        test_uflow_clear();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
